// File: rtl/bp_me_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 slave among several masters.
// Ownership is held for the whole cyc window; ack is returned to the owner only.
module bp_me_wb_arbiter #(
  parameter int num_masters_p = 2,
  parameter int adr_width_p   = 37,
  parameter int data_width_p  = 64,
  localparam int sel_width_lp = data_width_p / 8
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_masters_p*adr_width_p-1:0]  m_adr_i,
  input  logic [num_masters_p*data_width_p-1:0] m_dat_i,
  input  logic [num_masters_p-1:0]              m_cyc_i,
  input  logic [num_masters_p-1:0]              m_stb_i,
  input  logic [num_masters_p*sel_width_lp-1:0] m_sel_i,
  input  logic [num_masters_p-1:0]              m_we_i,
  input  logic [num_masters_p*3-1:0]            m_cti_i,
  input  logic [num_masters_p*2-1:0]            m_bte_i,
  output logic [data_width_p-1:0]               m_dat_o,
  output logic [num_masters_p-1:0]              m_ack_o,
  output logic [adr_width_p-1:0]                s_adr_o,
  output logic [data_width_p-1:0]               s_dat_o,
  output logic                                  s_cyc_o,
  output logic                                  s_stb_o,
  output logic [sel_width_lp-1:0]               s_sel_o,
  output logic                                  s_we_o,
  output logic [2:0]                            s_cti_o,
  output logic [1:0]                            s_bte_o,
  input  logic [data_width_p-1:0]               s_dat_i,
  input  logic                                  s_ack_i,
  output logic [num_masters_p-1:0]              grant_o
);

  localparam int iw_lp = $clog2(num_masters_p);

  typedef enum logic {e_idle, e_busy} state_e;

  state_e                   state_r, state_n;
  logic [num_masters_p-1:0] grant_r, grant_n;
  logic [iw_lp-1:0]         last_r, last_n;

  // First requester strictly after 'last', wrapping; scanning backwards so the
  // nearest one wins the final assignment.
  function automatic logic [iw_lp-1:0] rr_pick(input logic [num_masters_p-1:0] req,
                                               input logic [iw_lp-1:0] last);
    logic [iw_lp-1:0] pick;
    int j;
    pick = last;
    for (int i = num_masters_p; i >= 1; i--) begin
      j = (int'(last) + i) % num_masters_p;
      if (req[j]) pick = iw_lp'(j);
    end
    return pick;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      grant_r <= '0;
      last_r  <= iw_lp'(num_masters_p - 1);
    end else begin
      state_r <= state_n;
      grant_r <= grant_n;
      last_r  <= last_n;
    end
  end

  always_comb begin
    state_n = state_r;
    grant_n = grant_r;
    last_n  = last_r;
    case (state_r)
      e_idle: begin
        if (|m_cyc_i) begin
          state_n         = e_busy;
          last_n          = rr_pick(m_cyc_i, last_r);
          grant_n         = '0;
          grant_n[last_n] = 1'b1;
        end
      end
      e_busy: begin
        if (!m_cyc_i[last_r]) begin
          state_n = e_idle;
          grant_n = '0;
        end
      end
      default: begin
        state_n = e_idle;
        grant_n = '0;
      end
    endcase
  end

  // In e_busy last_r is the owner's index, so it drives the slave mux directly.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_ack_o = '0;
    if (state_r == e_busy) begin
      s_adr_o = m_adr_i[last_r*adr_width_p +: adr_width_p];
      s_dat_o = m_dat_i[last_r*data_width_p +: data_width_p];
      s_cyc_o = m_cyc_i[last_r];
      s_stb_o = m_stb_i[last_r] & m_cyc_i[last_r];
      s_sel_o = m_sel_i[last_r*sel_width_lp +: sel_width_lp];
      s_we_o  = m_we_i[last_r];
      s_cti_o = m_cti_i[last_r*3 +: 3];
      s_bte_o = m_bte_i[last_r*2 +: 2];
      m_ack_o[last_r] = s_ack_i & s_cyc_o & s_stb_o;
    end
  end

  assign m_dat_o = s_dat_i;
  assign grant_o = grant_r;

endmodule

// File: tb/tb_bp_me_wb_arbiter.sv
// Directed bench for bp_me_wb_arbiter: a 2-master instance for most scenarios
// and a 3-master instance for the round-robin rotation.
module tb_bp_me_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 2-master instance
  logic [73:0]  m_adr = '0;
  logic [127:0] m_dat = '0;
  logic [1:0]   m_cyc = '0, m_stb = '0, m_we = '0;
  logic [15:0]  m_sel = '0;
  logic [5:0]   m_cti = '0;
  logic [3:0]   m_bte = '0;
  logic [63:0]  m_dat_o;
  logic [1:0]   m_ack, grant;
  logic [36:0]  s_adr;
  logic [63:0]  s_dat_o, s_dat = '0;
  logic         s_cyc, s_stb, s_we, s_ack = 1'b0;
  logic [7:0]   s_sel;
  logic [2:0]   s_cti;
  logic [1:0]   s_bte;

  bp_me_wb_arbiter #(.num_masters_p(2)) dut (
    .clk_i(clk), .reset_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_sel_i(m_sel), .m_we_i(m_we), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_sel_o(s_sel), .s_we_o(s_we), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .grant_o(grant)
  );

  // 3-master instance
  logic [110:0] t_adr = '0;
  logic [191:0] t_dat = '0;
  logic [2:0]   t_cyc = '0, t_stb = '0, t_we = '0;
  logic [23:0]  t_sel = '0;
  logic [8:0]   t_cti = '0;
  logic [5:0]   t_bte = '0;
  logic [63:0]  t_dat_o, t_s_dat_o;
  logic [2:0]   t_ack, t_grant;
  logic [36:0]  t_s_adr;
  logic         t_s_cyc, t_s_stb, t_s_we;
  logic [7:0]   t_s_sel;
  logic [2:0]   t_s_cti;
  logic [1:0]   t_s_bte;

  bp_me_wb_arbiter #(.num_masters_p(3)) dut3 (
    .clk_i(clk), .reset_i(rst),
    .m_adr_i(t_adr), .m_dat_i(t_dat), .m_cyc_i(t_cyc), .m_stb_i(t_stb),
    .m_sel_i(t_sel), .m_we_i(t_we), .m_cti_i(t_cti), .m_bte_i(t_bte),
    .m_dat_o(t_dat_o), .m_ack_o(t_ack),
    .s_adr_o(t_s_adr), .s_dat_o(t_s_dat_o), .s_cyc_o(t_s_cyc), .s_stb_o(t_s_stb),
    .s_sel_o(t_s_sel), .s_we_o(t_s_we), .s_cti_o(t_s_cti), .s_bte_o(t_s_bte),
    .s_dat_i(64'h0), .s_ack_i(1'b0), .grant_o(t_grant)
  );

  task test_reset;
    #1 rst = 1'b1;
    s_dat = 64'h1234_5678;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
    checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin errors++; $display("FAIL rst_cyc_stb: got %b%b want 00", s_cyc, s_stb); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL rst_ack: got %b want 00", m_ack); end
    checks++; if (m_dat_o !== 64'h1234_5678) begin errors++; $display("FAIL rst_mdat: got %h want 12345678", m_dat_o); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL idle_ack_ignored: got %b want 00", m_ack); end
    @(negedge clk);
    s_ack = 1'b0;
  endtask

  task test_single_read;
    @(negedge clk);
    m_adr[37 +: 37] = 37'h1_2345_6789;
    m_sel[8 +: 8] = 8'hFF;
    m_cyc = 2'b10; m_stb = 2'b10;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rd_latency: s_cyc got %b want 0", s_cyc); end
    @(negedge clk); #1;
    checks++; if (s_cyc !== 1'b1 || grant !== 2'b10) begin errors++; $display("FAIL rd_grant: cyc %b grant %b want 1 10", s_cyc, grant); end
    checks++; if (s_adr !== 37'h1_2345_6789 || s_sel !== 8'hFF) begin errors++; $display("FAIL rd_mux: adr %h sel %h want 123456789 ff", s_adr, s_sel); end
    @(negedge clk);
    s_dat = 64'hDEAD_BEEF; s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL rd_ack: got %b want 10", m_ack); end
    checks++; if (m_dat_o !== 64'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", m_dat_o); end
    @(negedge clk);
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    #1;
    checks++; if (s_cyc !== 1'b0 || grant !== 2'b10) begin errors++; $display("FAIL rd_release: cyc %b grant %b want 0 10", s_cyc, grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_idle: grant %b want 00", grant); end
  endtask

  task test_simultaneous;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sim_first: grant %b want 01", grant); end
    @(negedge clk);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sim_gap: grant %b want 00", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10 || s_cyc !== 1'b1) begin errors++; $display("FAIL sim_second: grant %b cyc %b want 10 1", grant, s_cyc); end
    @(negedge clk);
    m_cyc = 2'b00; m_stb = 2'b00;
    @(negedge clk);
  endtask

  task test_burst;
    @(negedge clk);
    m_cyc = 2'b11; m_stb = 2'b11;
    m_cti[0 +: 3] = 3'b010; m_bte[0 +: 2] = 2'b01; m_we[0] = 1'b1;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL burst_grant: grant %b want 01", grant); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      s_ack = 1'b1;
      if (b == 3) m_cti[0 +: 3] = 3'b111;
      #1;
      checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL burst_ack%0d: got %b want 01", b, m_ack); end
      checks++; if (s_cti !== ((b == 3) ? 3'b111 : 3'b010) || s_bte !== 2'b01 || s_we !== 1'b1) begin errors++; $display("FAIL burst_ctl%0d: cti %b bte %b we %b", b, s_cti, s_bte, s_we); end
    end
    @(negedge clk);
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cti = '0; m_bte = '0; m_we = '0;
    #1;
    checks++; if (grant !== 2'b01 || s_cyc !== 1'b0) begin errors++; $display("FAIL burst_release: grant %b cyc %b want 01 0", grant, s_cyc); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL burst_gap: grant %b want 00", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_next: grant %b want 10", grant); end
    @(negedge clk);
    m_cyc = 2'b00; m_stb = 2'b00;
    @(negedge clk);
  endtask

  task test_stb_gap;
    @(negedge clk);
    m_cyc = 2'b11; m_stb = 2'b11;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL gap_grant: grant %b want 01", grant); end
    @(negedge clk); s_ack = 1'b1; #1;
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL gap_beat1: ack %b want 01", m_ack); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); m_stb[0] = 1'b0; #1;
      checks++; if (s_stb !== 1'b0 || s_cyc !== 1'b1 || grant !== 2'b01 || m_ack !== 2'b00) begin errors++; $display("FAIL gap_hold%0d: stb %b cyc %b grant %b ack %b", k, s_stb, s_cyc, grant, m_ack); end
    end
    @(negedge clk); m_stb[0] = 1'b1; #1;
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL gap_beat2: ack %b want 01", m_ack); end
    @(negedge clk);
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    @(negedge clk); @(negedge clk);
  endtask

  task test_drop_wait;
    @(negedge clk); m_cyc = 2'b01; m_stb = 2'b01;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL dw_grant: grant %b want 01", grant); end
    @(negedge clk); m_cyc = 2'b11;
    @(negedge clk); m_cyc = 2'b01;
    @(negedge clk); m_cyc = 2'b00; m_stb = 2'b00;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL dw_idle1: grant %b want 00", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin errors++; $display("FAIL dw_idle2: grant %b cyc %b want 00 0", grant, s_cyc); end
  endtask

  task test_reset_mid_burst;
    @(negedge clk);
    m_cyc = 2'b01; m_stb = 2'b01; m_cti[0 +: 3] = 3'b010;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmb_grant: grant %b want 01", grant); end
    @(negedge clk); s_ack = 1'b1; #1;
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL rmb_beat: ack %b want 01", m_ack); end
    #2 rst = 1'b1;
    m_cyc = 2'b11; m_stb = 2'b11;
    #1;
    checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0 || grant !== 2'b00 || m_ack !== 2'b00 || s_cti !== 3'b000) begin errors++; $display("FAIL rmb_async: cyc %b stb %b grant %b ack %b cti %b", s_cyc, s_stb, grant, m_ack, s_cti); end
    @(negedge clk);
    rst = 1'b0; s_ack = 1'b0; m_cti = '0;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmb_prio: grant %b want 01", grant); end
    @(negedge clk); m_cyc = 2'b00; m_stb = 2'b00;
    @(negedge clk);
  endtask

  task test_three_rotate;
    logic [2:0] exp [1:7];
    exp[1] = 3'b001; exp[2] = 3'b000; exp[3] = 3'b010; exp[4] = 3'b000;
    exp[5] = 3'b100; exp[6] = 3'b000; exp[7] = 3'b001;
    @(negedge clk); t_cyc = 3'b111; t_stb = 3'b111;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); #1;
      checks++; if (t_grant !== exp[k]) begin errors++; $display("FAIL rot_c%0d: grant %b want %b", k, t_grant, exp[k]); end
      // Owner drops cyc for one cycle after its grant, then re-requests.
      t_cyc = 3'b111 & ~exp[k];
      t_stb = t_cyc;
    end
    t_cyc = '0; t_stb = '0;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_simultaneous;
    test_burst;
    test_stb_gap;
    test_drop_wait;
    test_reset_mid_burst;
    test_three_rotate;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
